// File: rtl/hss_envelope_if.sv
// Stream bundle between the low-pass filter, the envelope extractor and its consumer.
// The master side drives samples, clear and ready; the slave side returns the envelope.
interface hss_envelope_if;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        overrun;

  modport master (
    output clr, in_valid, in_data, out_ready,
    input  out_valid, out_data, overrun
  );

  modport slave (
    input  clr, in_valid, in_data, out_ready,
    output out_valid, out_data, overrun
  );
endinterface

// File: rtl/hss_envelope.sv
// Rectifies filtered samples, averages them over a 2^WIN_LOG2 sliding window and
// emits one decimated envelope sample per DEC inputs over a valid/ready handshake.
module hss_envelope #(
  parameter int WIN_LOG2 = 5,
  parameter int DEC      = 8
) (
  input logic           i_clk,
  input logic           i_rst_n,
  hss_envelope_if.slave bus
);

  localparam int W     = 1 << WIN_LOG2;
  localparam int SUM_W = 16 + WIN_LOG2;
  localparam int CNT_W = (DEC > 1) ? $clog2(DEC) : 1;

  typedef enum logic {FILL, RUN} state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [14:0]          r_absR;
  logic                 r_v1;
  logic [14:0]          r_buf [W];
  logic [WIN_LOG2-1:0]  r_wrPtr;
  logic [WIN_LOG2:0]    r_fill;
  logic [SUM_W-1:0]     r_sum;
  logic [CNT_W-1:0]     r_decCnt;
  logic                 r_emit;
  logic [15:0]          r_avg;
  logic                 r_avgEmit;
  logic [15:0]          r_outData;
  logic                 r_outValid;
  logic                 r_overrun;
  logic [14:0]          w_abs;
  logic [14:0]          w_oldest;
  logic [SUM_W-1:0]     w_sumNext;
  logic [15:0]          w_avg;

  // -32768 has no positive counterpart in 16 bits, so it saturates to 32767.
  always_comb begin
    w_abs = bus.in_data[14:0];
    if (bus.in_data == 16'h8000) begin
      w_abs = 15'h7FFF;
    end else if (bus.in_data[15]) begin
      w_abs = (~bus.in_data[14:0]) + 15'd1;
    end
  end

  always_comb begin
    w_oldest  = (r_state == RUN) ? r_buf[r_wrPtr] : 15'd0;
    w_sumNext = r_sum + SUM_W'(r_absR) - SUM_W'(w_oldest);
    w_avg     = 16'(r_sum >> WIN_LOG2);
  end

  always_comb begin
    w_stateNext = r_state;
    if (bus.clr) begin
      w_stateNext = FILL;
    end else if (r_state == FILL && r_v1 && r_fill == (WIN_LOG2+1)'(W - 1)) begin
      w_stateNext = RUN;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_absR <= '0;
      r_v1   <= 1'b0;
    end else if (bus.clr) begin
      r_absR <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_absR <= w_abs;
      end
    end
  end

  // Window storage is never reset; the FILL state masks slots not yet written.
  always_ff @(posedge i_clk) begin
    if (r_v1 && !bus.clr) begin
      r_buf[r_wrPtr] <= r_absR;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum    <= '0;
      r_wrPtr  <= '0;
      r_fill   <= '0;
      r_decCnt <= '0;
      r_emit   <= 1'b0;
    end else if (bus.clr) begin
      r_sum    <= '0;
      r_wrPtr  <= '0;
      r_fill   <= '0;
      r_decCnt <= '0;
      r_emit   <= 1'b0;
    end else begin
      r_emit <= 1'b0;
      if (r_v1) begin
        r_sum   <= w_sumNext;
        r_wrPtr <= r_wrPtr + WIN_LOG2'(1);
        if (r_fill != (WIN_LOG2+1)'(W)) begin
          r_fill <= r_fill + (WIN_LOG2+1)'(1);
        end
        if (r_decCnt == CNT_W'(DEC - 1)) begin
          r_decCnt <= '0;
          r_emit   <= 1'b1;
        end else begin
          r_decCnt <= r_decCnt + CNT_W'(1);
        end
      end
    end
  end

  // Registered divide stage keeps the window adder off the output register path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_avg     <= '0;
      r_avgEmit <= 1'b0;
    end else if (bus.clr) begin
      r_avg     <= '0;
      r_avgEmit <= 1'b0;
    end else begin
      r_avgEmit <= r_emit;
      if (r_emit) begin
        r_avg <= w_avg;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (bus.clr) begin
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= r_avgEmit && r_outValid && !bus.out_ready;
      if (r_avgEmit) begin
        r_outData  <= r_avg;
        r_outValid <= 1'b1;
      end else if (r_outValid && bus.out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_outData;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_hss_envelope.sv
// Self-checking bench for hss_envelope: directed scenarios plus random traffic,
// compared every cycle against a window-average reference model.
module tb_hss_envelope;

  localparam int WIN_LOG2 = 5;
  localparam int DEC      = 8;
  localparam int W        = 1 << WIN_LOG2;
  localparam int LAT      = 3;

  logic clk;
  logic rst_n;

  hss_envelope_if bus ();

  hss_envelope #(.WIN_LOG2(WIN_LOG2), .DEC(DEC)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;
  int edgeCount = 0;
  int overrunSeen = 0;
  int firstValidEdge = -1;
  int got[$];

  // Reference model: the last W rectified samples and a schedule of due outputs.
  int hist[$];
  int accCount = 0;
  int dueQ[$];
  int valQ[$];
  bit expValid = 1'b0;
  int expData = 0;
  bit expOverrun = 1'b0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    hist.delete();
    dueQ.delete();
    valQ.delete();
    accCount   = 0;
    expValid   = 1'b0;
    expData    = 0;
    expOverrun = 1'b0;
  endtask

  function automatic int rectify(input logic [15:0] d);
    int s;
    s = int'($signed(d));
    if (s == -32768) return 32767;
    return (s < 0) ? -s : s;
  endfunction

  task automatic modelEdge(input bit v, input logic [15:0] d, input bit rdy, input bit c);
    int s;
    if (c) begin
      modelClear();
      return;
    end
    expOverrun = 1'b0;
    if (dueQ.size() > 0 && dueQ[0] == edgeCount) begin
      void'(dueQ.pop_front());
      expOverrun = expValid && !rdy;
      expData    = valQ.pop_front();
      expValid   = 1'b1;
    end else if (expValid && rdy) begin
      expValid = 1'b0;
    end
    if (v) begin
      hist.push_back(rectify(d));
      if (hist.size() > W) void'(hist.pop_front());
      accCount++;
      if (accCount % DEC == 0) begin
        s = 0;
        foreach (hist[i]) s += hist[i];
        dueQ.push_back(edgeCount + LAT);
        valQ.push_back(s / W);
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    checkEq({tag, "_valid"},   32'(bus.out_valid), 32'(expValid));
    checkEq({tag, "_data"},    32'(bus.out_data),  32'(expData));
    checkEq({tag, "_overrun"}, 32'(bus.overrun),   32'(expOverrun));
  endtask

  task automatic applyStimulus(input bit v, input logic [15:0] d, input bit rdy, input bit c,
                               input string tag);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    bus.clr       = c;
    if (bus.out_valid && rdy && !c) got.push_back(int'(bus.out_data));
    @(posedge clk);
    #1;
    edgeCount++;
    modelEdge(v, d, rdy, c);
    checkOutput(tag);
    if (bus.overrun) overrunSeen++;
    if (bus.out_valid && firstValidEdge < 0) firstValidEdge = edgeCount;
  endtask

  task automatic idle(input int n, input bit rdy, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'd0, rdy, 1'b0, tag);
  endtask

  task automatic checkRamp(input string tag);
    int ramp[4] = '{250, 500, 750, 1000};
    checkEq({tag, "_count"}, 32'(got.size() >= 4), 32'd1);
    if (got.size() >= 4) begin
      for (int i = 0; i < 4; i++) checkEq($sformatf("%s_%0d", tag, i), 32'(got[i]), 32'(ramp[i]));
    end
  endtask

  initial begin
    int eighthEdge;
    int ovStart;
    logic [15:0] rd;

    rst_n         = 1'b0;
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'd0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    modelClear();
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Constant +1000 every cycle, consumer always ready
    got.delete();
    firstValidEdge = -1;
    eighthEdge = 0;
    overrunSeen = 0;
    for (int i = 0; i < 48; i++) begin
      applyStimulus(1'b1, 16'd1000, 1'b1, 1'b0, "const");
      if (i == 7) eighthEdge = edgeCount;
    end
    idle(6, 1'b1, "const_tail");
    checkEq("first_valid_latency", 32'(firstValidEdge - eighthEdge), 32'd3);
    checkRamp("const_ramp");
    if (got.size() >= 6) checkEq("const_steady", 32'(got[5]), 32'd1000);
    checkEq("const_no_overrun", 32'(overrunSeen), 32'd0);

    // Overrun: consumer stalled for 20 samples
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, "ovr_clr");
    overrunSeen = 0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 16'd1000, 1'b0, 1'b0, "ovr");
    idle(5, 1'b0, "ovr_hold");
    ovStart = overrunSeen;
    checkEq("ovr_pulses", 32'(ovStart), 32'd1);
    checkEq("ovr_valid_held", 32'(bus.out_valid), 32'd1);
    checkEq("ovr_data", 32'(bus.out_data), 32'd500);
    idle(3, 1'b1, "ovr_drain");

    // Alternating +/-1000, then saturating -32768
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, "alt_clr");
    got.delete();
    for (int i = 0; i < 64; i++)
      applyStimulus(1'b1, (i % 2 == 0) ? 16'd1000 : 16'hFC18, 1'b1, 1'b0, "alt");
    idle(5, 1'b1, "alt_tail");
    checkEq("alt_count", 32'(got.size()), 32'd8);
    if (got.size() == 8) for (int i = 4; i < 8; i++)
      checkEq($sformatf("alt_run_%0d", i), 32'(got[i]), 32'd1000);
    got.delete();
    for (int i = 0; i < 48; i++) applyStimulus(1'b1, 16'h8000, 1'b1, 1'b0, "sat");
    idle(5, 1'b1, "sat_tail");
    checkEq("sat_final", 32'(got.size() > 0 ? got[got.size()-1] : -1), 32'd32767);

    // Step 0 -> 2000 after steady state, crossing the write-pointer wrap
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b1, "step_clr");
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 16'd0, 1'b1, 1'b0, "step_zero");
    idle(5, 1'b1, "step_gap");
    got.delete();
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 16'd2000, 1'b1, 1'b0, "step");
    idle(5, 1'b1, "step_tail");
    checkEq("step_count", 32'(got.size()), 32'd5);
    if (got.size() == 5) for (int i = 0; i < 5; i++)
      checkEq($sformatf("step_%0d", i), 32'(got[i]), 32'((i < 4) ? 500 * (i + 1) : 2000));

    // Synchronous clear mid-window, then the ramp must repeat exactly
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 16'd3000, 1'b0, 1'b0, "clr_pre");
    applyStimulus(1'b1, 16'd3000, 1'b0, 1'b1, "clr_edge");
    checkEq("clr_valid", 32'(bus.out_valid), 32'd0);
    checkEq("clr_data", 32'(bus.out_data), 32'd0);
    got.delete();
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 16'd1000, 1'b1, 1'b0, "clr_ramp");
    idle(5, 1'b1, "clr_tail");
    checkRamp("clr_ramp");

    // Asynchronous reset mid-window
    for (int i = 0; i < 13; i++) applyStimulus(1'b1, 16'd5000, 1'b0, 1'b0, "arst_pre");
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    modelClear();
    checkOutput("arst");
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 16'd1000, 1'b1, 1'b0, "arst_ramp");
    idle(5, 1'b1, "arst_tail");
    checkRamp("arst_ramp");

    // Random traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      rd = 16'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, rd, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 149) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/hss_envelope.md
# hss_envelope

Envelope extractor directly downstream of the Butterworth low-pass stage in the HSS front end. It takes the filtered signed 16-bit samples, rectifies them, and averages them over a sliding window with a circular buffer. It then decimates the result and presents one envelope sample per DEC inputs to the segmentation logic / AIRISC peripheral through a valid/ready handshake.

## Interface
- WIN_LOG2, 5: log2 of moving-average window length (window W = 2^WIN_LOG2, legal 2..8)
- DEC, 8: decimation factor, one output per DEC accepted inputs (legal 1..255)
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear; restarts the envelope without a reset
- in_valid  in  1  sample strobe from the filter stage; no back-pressure, always accepted
- in_data  in  16  signed filtered sample (filter output, Q-format passed through unchanged)
- out_valid  out  1  envelope sample available
- out_ready  in  1  consumer accepts out_data when high with out_valid
- out_data  out  16  unsigned envelope sample
- overrun  out  1  one-cycle pulse when an unconsumed output is overwritten

## Operation
- Stage 1 (rectify): on in_valid, abs_r <= |in_data|. The value -32768 saturates to 32767. v1 <= in_valid.
- Stage 2 (accumulate), when v1:
  - oldest = buf[wr_ptr] if fill == W, else 0.
  - sum <= sum + abs_r - oldest.
  - buf[wr_ptr] <= abs_r.
  - wr_ptr <= wr_ptr + 1, wrapping modulo W.
  - fill <= min(fill+1, W).
  - dec_cnt increments. On reaching DEC-1 it wraps to 0 and sets emit.
- Arithmetic widths: sum is unsigned 16+WIN_LOG2 bits and can never overflow. avg = sum >> WIN_LOG2, truncating, and always fits in 16 bits.
- Buffer contents are not reset. The fill counter masks stale entries, so during fill the sum equals the sum of the samples received so far, divided by W.
- States are FILL (fill < W) and RUN (fill == W). FILL -> RUN on the W-th accepted sample. clr or RST returns to FILL.
- Stage 3 (output):
  - When emit: out_data <= new avg and out_valid <= 1.
  - If out_valid was 1 and out_ready was 0 in that same cycle, overrun = 1 for one cycle. The old value is lost and the new value is kept.
  - If out_ready is 1 in the emit cycle, the new value loads with no overrun and out_valid stays 1.
  - When no emit and out_valid && out_ready: out_valid <= 0.
- clr (synchronous, takes priority over in_valid in the same cycle) zeroes:
  - sum, fill, wr_ptr, dec_cnt, v1, emit
  - out_valid, out_data, overrun
  - any in-flight sample is discarded.

## Timing
- Reset values: out_valid=0, out_data=0, overrun=0, sum=0, fill=0, wr_ptr=0, dec_cnt=0, v1=0, emit=0.
- Reset deasserting mid-stream: the first sample accepted is the one at the first rising edge with RST high.
- Latency: sample accepted at edge n; its contribution appears in out_data with out_valid=1 after edge n+3 (when it is a DEC-th sample).
- Full throughput: in_valid may be high every cycle. Back-to-back wr_ptr wrap and buffer read of the same slot must return the pre-write value (read-before-write).
- out_data is stable while out_valid=1 and out_ready=0, except on overrun.
- out_valid never deasserts without a handshake (out_valid && out_ready at a rising edge), clr or RST.

## Test plan
- **Constant +1000, W=32, DEC=8, in_valid every cycle**: outputs 250, 500, 750, 1000, then 1000 forever. The first out_valid comes 3 cycles after the 8th sample.
- **Alternating +1000/-1000, out_ready=1**: after fill, every output is 1000. A constant -32768 input settles at 32767.
- **Overrun**: out_ready=0 for 20 samples → out_valid stays 1. overrun pulses exactly once, at the 16th sample's emit. out_data then shows the 2nd average (500 with the constant-1000 stimulus).
- **Simultaneous emit and handshake**: out_ready=1 in the emit cycle → the new value is loaded, no overrun, out_valid held at 1.
- **Step 0→2000 after steady state**: outputs ramp by 2000·8/32 = 500 per output and reach 2000 after 32 samples. This checks that the oldest value is removed correctly across wr_ptr wrap.
- **clr or async RST asserted mid-window**: all outputs are 0 immediately (RST) or at the next edge (clr). Refeeding constant 1000 repeats the 250, 500, 750, 1000 ramp exactly, proving stale buffer data is masked.
